// File: rtl/parking_flash_ctrl.sv
// parking_flash_ctrl: multi-channel status indicator flasher sharing one blink prescaler.
module parking_flash_ctrl #(
   parameter int N_CH        = 4,
   parameter int HALF_PERIOD = 15000000,
   parameter int TOGGLES     = 7,
   parameter int RETRIGGER   = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] status,
   input  logic [N_CH-1:0] trigger,
   input  logic [N_CH-1:0] cont,
   output logic [N_CH-1:0] led,
   output logic [N_CH-1:0] busy,
   output logic [N_CH-1:0] done
);
   localparam int TW = $clog2(HALF_PERIOD);
   localparam int CW = $clog2(TOGGLES + 1);
   typedef enum logic {IDLE, FLASH} state_t;
   logic [TW-1:0]   timer_q, timer_d;
   logic            tick;
   state_t          state_q [N_CH];
   state_t          state_d [N_CH];
   logic [CW-1:0]   cnt_q [N_CH];
   logic [CW-1:0]   cnt_d [N_CH];
   logic [N_CH-1:0] led_q, led_d, done_q, done_d;
   assign led  = led_q;
   assign done = done_q;
   always_comb begin
      tick    = timer_q == TW'(HALF_PERIOD - 1);
      timer_d = tick ? '0 : timer_q + 1'b1;
      busy    = '0;
      led_d   = led_q;
      done_d  = '0;
      for (int i = 0; i < N_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         busy[i]    = state_q[i] == FLASH;
         if (state_q[i] == IDLE) begin
            led_d[i] = status[i];
            if (trigger[i] && status[i]) begin
               state_d[i] = FLASH;
               cnt_d[i]   = CW'(TOGGLES);
               led_d[i]   = 1'b1;
            end
         end else if (!status[i]) begin
            state_d[i] = IDLE;
            led_d[i]   = 1'b0;
         end else if (trigger[i] && RETRIGGER != 0) begin
            cnt_d[i] = CW'(TOGGLES);
         end else if (tick) begin
            // a frozen (cont) burst never completes, it only keeps toggling
            if (cnt_q[i] == CW'(1) && !cont[i]) begin
               state_d[i] = IDLE;
               led_d[i]   = status[i];
               done_d[i]  = 1'b1;
            end else begin
               led_d[i] = ~led_q[i];
               cnt_d[i] = cont[i] ? cnt_q[i] : cnt_q[i] - 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer_q <= '0;
         led_q   <= '0;
         done_q  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         timer_q <= timer_d;
         led_q   <= led_d;
         done_q  <= done_d;
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end
endmodule
